// File: rtl/seq_divider_16by8_if.sv
// Start/done handshake and operand/result bundle for seq_divider_16by8.
interface seq_divider_16by8_if #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_16by8.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional early divide-by-zero completion: define SEQ_DIVIDER_DIV_BY_ZERO_EN.
module seq_divider_16by8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_divider_16by8_if.slave bus
);
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [DIVISOR_W:0]    r_reg;
    logic [DIVIDEND_W-1:0] q_reg;
    logic [DIVISOR_W-1:0]  d_reg;
    logic                  busy_r, done_r;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;
    logic                  load, iterate, finish;
    logic                  dz_early;

    // One restoring step on the current partial remainder / quotient pair.
    logic [DIVISOR_W:0]    r_sh;
    logic [DIVISOR_W+1:0]  t;
    logic                  ge;
    logic [DIVISOR_W:0]    r_it;
    logic [DIVIDEND_W-1:0] q_it;

    assign r_sh = {r_reg[DIVISOR_W-1:0], q_reg[DIVIDEND_W-1]};
    assign t    = {1'b0, r_sh} - {2'b00, d_reg};
    assign ge   = ~t[DIVISOR_W+1];
    assign r_it = ge ? t[DIVISOR_W:0] : r_sh;
    assign q_it = {q_reg[DIVIDEND_W-2:0], ge};

`ifdef SEQ_DIVIDER_DIV_BY_ZERO_EN
    logic dz_reg;
    logic dbz_r;
    assign dz_early = dz_reg;
`else
    assign dz_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        iterate   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                iterate = 1'b1;
                if (cnt == '0 || dz_early) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            busy_r <= (state_nxt == RUN);
            done_r <= (state_nxt == DONE);
            if (load) begin
                d_reg <= bus.divisor;
                q_reg <= bus.dividend;
                r_reg <= '0;
                cnt   <= CNT_W'(DIVIDEND_W - 1);
            end else if (iterate) begin
                q_reg <= q_it;
                r_reg <= r_it;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (finish) begin
                if (dz_early) begin
                    // q_reg still holds the untouched dividend on the early exit.
                    quotient_r  <= '1;
                    remainder_r <= q_reg[DIVISOR_W-1:0];
                end else begin
                    quotient_r  <= q_it;
                    remainder_r <= r_it[DIVISOR_W-1:0];
                end
            end
        end
    end

`ifdef SEQ_DIVIDER_DIV_BY_ZERO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_reg <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            if (load) begin
                dz_reg <= (bus.divisor == '0);
            end
            if (finish) begin
                dbz_r <= dz_reg;
            end
        end
    end
    assign bus.div_by_zero = dbz_r;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
endmodule

// File: tb/tb_seq_divider_16by8.sv
// Randomized self-checking bench for seq_divider_16by8 against an arithmetic reference.
module tb_seq_divider_16by8;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seq_divider_16by8_if bus ();

    seq_divider_16by8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                    output logic [15:0] q, output logic [7:0] r);
        if (b == 8'd0) begin
            q = 16'hFFFF;
            r = a[7:0];
        end else begin
            q = a / b;
            r = 8'(a % b);
        end
    endfunction

    function automatic int ref_lat(input logic [7:0] b);
`ifdef SEQ_DIVIDER_DIV_BY_ZERO_EN
        return (b == 8'd0) ? 1 : 16;
`else
        return 16;
`endif
    endfunction

    function automatic logic ref_dbz(input logic [7:0] b);
`ifdef SEQ_DIVIDER_DIV_BY_ZERO_EN
        return (b == 8'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Waits (bounded) for done after the accepting edge; returns samples taken
    // (sample 1 is just after the accepting edge) and number of busy samples.
    task automatic wait_done(input bit hold, input bit scramble, output int cyc, output int busy_cnt);
        bit seen;
        cyc = 0;
        busy_cnt = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold) bus.start = 1'b0;
            if (scramble) begin
                bus.dividend = 16'($urandom);
                bus.divisor  = 8'($urandom);
            end
            if (bus.done) seen = 1;
            else if (bus.busy) busy_cnt++;
        end
        if (!seen) check("done_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic [15:0] eq;
        logic [7:0]  er;
        ref_div(a, b, eq, er);
        check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_r"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ref_dbz(b)));
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b, input bit scramble);
        int cyc, busy_cnt;
        logic [15:0] eq;
        logic [7:0]  er;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        wait_done(1'b0, scramble, cyc, busy_cnt);
        check({tag, "_lat"}, 32'(cyc - 1), 32'(ref_lat(b)));
        check({tag, "_busy"}, 32'(busy_cnt), 32'(ref_lat(b)));
        check_result(tag, a, b);
        ref_div(a, b, eq, er);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"}, {8'(bus.remainder), 8'd0, bus.quotient}, {er, 8'd0, eq});
    endtask

    initial begin
        int cyc, busy_cnt, dones;
        logic [15:0] a;
        logic [7:0]  b, x, y;
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #1;
        check("rst_async", {27'd0, bus.busy, bus.done, bus.div_by_zero, 2'b00}, 32'd0);
        check("rst_qr", {8'(bus.remainder), 8'd0, bus.quotient}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("sq255", 16'hFE01, 8'd255, 1'b0);
        do_op("d1000_7", 16'd1000, 8'd7, 1'b1);
        do_op("d5_10", 16'd5, 8'd10, 1'b0);
        do_op("ffff_1", 16'hFFFF, 8'd1, 1'b0);
        do_op("zero_div", 16'h1234, 8'd0, 1'b0);

        // start held through RUN, then a back-to-back op accepted in DONE
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd7;
        @(posedge clk);
        wait_done(1'b1, 1'b0, cyc, busy_cnt);
        check("hold_lat", 32'(cyc - 1), 32'd16);
        check_result("hold", 16'd1000, 8'd7);
        bus.dividend = 16'd100;
        bus.divisor  = 8'd3;
        @(posedge clk);
        wait_done(1'b0, 1'b0, cyc, busy_cnt);
        check("b2b_gap", 32'(cyc), 32'd17);
        check_result("b2b", 16'd100, 8'd3);

        // Reset in the middle of an iteration run
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_qr", {8'(bus.remainder), 8'd0, bus.quotient}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("no_done_after_rst", 32'(dones), 32'd0);
        do_op("d200_9", 16'd200, 8'd9, 1'b0);

        // Random operands, including products of two 8-bit factors
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    x = 8'($urandom_range(1, 255));
                    y = 8'($urandom);
                    a = 16'(x) * 16'(y);
                    b = x;
                end
                1: begin
                    a = 16'($urandom);
                    b = 8'd0;
                end
                default: begin
                    a = 16'($urandom);
                    b = 8'($urandom);
                end
            endcase
            do_op("rand", a, b, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
